// File: rtl/usb_dp_frontend.sv
// USB full-speed D+/D- front end: tristate pin drive, synchroniser, glitch filter,
// transmit/turnaround receive mask, line-state decode and bus-reset (long SE0) detect.
module usb_dp_frontend #(
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_LEN        = 1,
  parameter int TURNAROUND_CYCLES = 2,
  parameter int SE0_RESET_CYCLES  = 120
) (
  input  logic       clk48,
  input  logic       rst_n,
  inout  wire        pinP,
  inout  wire        pinN,
  input  logic       OUT_EN,
  input  logic       dataOutP,
  input  logic       dataOutN,
  output logic       dataInP,
  output logic       dataInN,
  output logic [1:0] lineState,
  output logic       lineChange,
  output logic       se0Long
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = (TURNAROUND_CYCLES > 0) ? $clog2(TURNAROUND_CYCLES + 1) : 1;
  localparam int SCW = $clog2(SE0_RESET_CYCLES + 1);

  // Pair encoding is {N,P}, which is also the lineState encoding.
  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // Plain tristate; synthesis maps this onto the I/O cell with an unregistered input.
  assign pinP = OUT_EN ? dataOutP : 1'bz;
  assign pinN = OUT_EN ? dataOutN : 1'bz;

  logic [1:0]                  pinRaw;
  logic [SYNC_STAGES-1:0][1:0] syncQ;
  logic [1:0]                  cand, candPrev, filt, filtNext;
  logic [FCW-1:0]              fCnt, fCntNext;
  logic [FCW:0]                step;
  logic [TCW-1:0]              taCnt, taNext;
  logic [SCW-1:0]              se0Cnt, se0Next;
  logic                        outEnQ, fall, masked, lcNext;

  assign pinRaw = {pinN, pinP};
  assign cand   = syncQ[SYNC_STAGES-1];

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      syncQ <= {SYNC_STAGES{LINE_J}};
    end else begin
      syncQ[0] <= pinRaw;
      for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
    end
  end

  always_comb begin
    fall     = outEnQ & ~OUT_EN;
    // With zero turnaround the falling cycle itself is already unmasked.
    masked   = OUT_EN | (taCnt != '0) | (fall & (TURNAROUND_CYCLES > 0));

    taNext = taCnt;
    if (OUT_EN)              taNext = '0;
    else if (fall)           taNext = TCW'(TURNAROUND_CYCLES);
    else if (taCnt != '0)    taNext = taCnt - 1'b1;

    filtNext = filt;
    fCntNext = '0;
    step     = '0;
    if (masked) begin
      filtNext = LINE_J;
    end else if (cand != filt) begin
      // A new differing value mid-count restarts the run at one sample.
      step = ((fCnt != '0) && (cand != candPrev)) ? (FCW+1)'(1) : ({1'b0, fCnt} + 1'b1);
      if (step >= (FCW+1)'(FILTER_LEN)) filtNext = cand;
      else                              fCntNext = step[FCW-1:0];
    end

    lcNext = (filtNext != filt) & ~masked;

    se0Next = '0;
    if (filtNext == LINE_SE0)
      se0Next = (se0Cnt >= SCW'(SE0_RESET_CYCLES)) ? se0Cnt : se0Cnt + 1'b1;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      filt       <= LINE_J;
      candPrev   <= LINE_J;
      fCnt       <= '0;
      taCnt      <= '0;
      outEnQ     <= 1'b0;
      lineChange <= 1'b0;
      se0Cnt     <= '0;
    end else begin
      filt       <= filtNext;
      candPrev   <= cand;
      fCnt       <= fCntNext;
      taCnt      <= taNext;
      outEnQ     <= OUT_EN;
      lineChange <= lcNext;
      se0Cnt     <= se0Next;
    end
  end

  assign dataInP   = filt[0];
  assign dataInN   = filt[1];
  assign lineState = filt;
  assign se0Long   = (se0Cnt >= SCW'(SE0_RESET_CYCLES));

endmodule

// File: tb/tb_usb_dp_frontend.sv
// Scoreboard bench: two front ends (default, and 3-stage sync / 2-sample filter) share
// one stimulus; expected outputs are queued per cycle and checked by a separate monitor.
module tb_usb_dp_frontend;

  localparam logic [1:0] J = 2'b01, K = 2'b10, SE0 = 2'b00, SE1 = 2'b11;
  localparam int LA = 3, LB = 5;      // hand-derived stages+filter latency per DUT
  localparam int FLA = 1, FLB = 2;    // filter lengths
  localparam int TA = 2;              // turnaround cycles
  localparam int NSE0 = 120;

  logic clk48 = 1'b0;
  logic rst_n, oe, doP, doN, extP, extN;
  wire  pinPA, pinNA, pinPB, pinNB;
  logic dInPA, dInNA, lcA, s0A, dInPB, dInNB, lcB, s0B;
  logic [1:0] lsA, lsB;

  assign pinPA = oe ? 1'bz : extP;
  assign pinNA = oe ? 1'bz : extN;
  assign pinPB = oe ? 1'bz : extP;
  assign pinNB = oe ? 1'bz : extN;

  usb_dp_frontend dutA (
    .clk48(clk48), .rst_n(rst_n), .pinP(pinPA), .pinN(pinNA), .OUT_EN(oe),
    .dataOutP(doP), .dataOutN(doN), .dataInP(dInPA), .dataInN(dInNA),
    .lineState(lsA), .lineChange(lcA), .se0Long(s0A));

  usb_dp_frontend #(.SYNC_STAGES(3), .FILTER_LEN(2), .TURNAROUND_CYCLES(2),
                    .SE0_RESET_CYCLES(120)) dutB (
    .clk48(clk48), .rst_n(rst_n), .pinP(pinPB), .pinN(pinNB), .OUT_EN(oe),
    .dataOutP(doP), .dataOutN(doN), .dataInP(dInPB), .dataInN(dInNB),
    .lineState(lsB), .lineChange(lcB), .se0Long(s0B));

  always #5 clk48 = ~clk48;

  int cyc = 0;
  always @(posedge clk48) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         d;
    logic [1:0] ls;
    logic       lc;
    logic       s0;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  logic [5:0] got, req;

  task automatic want(int d, int at, logic [1:0] ls, logic lc, logic s0, string nm);
    exp_t e;
    e.at = at; e.d = d; e.ls = ls; e.lc = lc; e.s0 = s0; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic wantSpan(int d, int a, int b, logic [1:0] ls, logic lc, logic s0, string nm);
    for (int c = a; c <= b; c++) want(d, c, ls, lc, s0, nm);
  endtask

  // Stable pin pulse of w cycles from idle J, seen by a DUT with latency L.
  task automatic pulseExp(int d, int t, int L, int w, logic [1:0] ls, string nm);
    wantSpan(d, t+1, t+L-1, J, 1'b0, 1'b0, nm);
    want(d, t+L, ls, 1'b1, 1'b0, nm);
    wantSpan(d, t+L+1, t+L+w-1, ls, 1'b0, 1'b0, nm);
    want(d, t+L+w, J, 1'b1, 1'b0, nm);
    wantSpan(d, t+L+w+1, t+L+w+2, J, 1'b0, 1'b0, nm);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic pins(logic [1:0] v);
    extN = v[1];
    extP = v[0];
  endtask

  // Monitor: outputs are compared on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk48);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        got = (sb[i].d == 0) ? {dInNA, dInPA, lsA, lcA, s0A} : {dInNB, dInPB, lsB, lcB, s0B};
        req = {sb[i].ls, sb[i].ls, sb[i].lc, sb[i].s0};
        checks++;
        if (sb[i].at < cyc || got !== req) begin
          errors++;
          $display("FAIL %s dut%0d cyc=%0d: got {N,P,ls,lc,se0Long}=%b required %b",
                   sb[i].nm, sb[i].d, sb[i].at, got, req);
        end
        sb.delete(i);
      end
    end
  end

  int t;
  int Ls[2] = '{LA, LB};
  int Fl[2] = '{FLA, FLB};
  int nowrap[4] = '{200, 500, 800, 1000};

  initial begin
    rst_n = 1'b0; oe = 1'b0; doP = 1'b0; doN = 1'b0;
    pins(J);

    for (int d = 0; d < 2; d++) wantSpan(d, 1, 4, J, 1'b0, 1'b0, "rst_hold");
    tick(4);
    checks++;
    if ({dInNA, dInPA, lsA, lcA, s0A} !== {J, J, 2'b00}) begin
      errors++;
      $display("FAIL rst_hold_direct dutA: %b", {dInNA, dInPA, lsA, lcA, s0A});
    end
    checks++;
    if ({dInNB, dInPB, lsB, lcB, s0B} !== {J, J, 2'b00}) begin
      errors++;
      $display("FAIL rst_hold_direct dutB: %b", {dInNB, dInPB, lsB, lcB, s0B});
    end
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) wantSpan(d, cyc+1, cyc+4, J, 1'b0, 1'b0, "rst_idle");
    tick(4);
    checks++;
    if ({dInNA, dInPA, lsA, lcA, s0A} !== {J, J, 2'b00}) begin
      errors++;
      $display("FAIL rst_idle_direct dutA: %b", {dInNA, dInPA, lsA, lcA, s0A});
    end
    checks++;
    if ({dInNB, dInPB, lsB, lcB, s0B} !== {J, J, 2'b00}) begin
      errors++;
      $display("FAIL rst_idle_direct dutB: %b", {dInNB, dInPB, lsB, lcB, s0B});
    end

    // J->K latency, held 8 cycles
    t = cyc;
    pins(K);
    for (int d = 0; d < 2; d++) pulseExp(d, t, Ls[d], 8, K, "latency");
    tick(8); pins(J); tick(12);

    // One-cycle SE0: passes the unfiltered DUT, rejected by the 2-sample filter
    t = cyc;
    pins(SE0);
    pulseExp(0, t, LA, 1, SE0, "glitch1_a");
    wantSpan(1, t+1, t+8, J, 1'b0, 1'b0, "glitch1_b");
    tick(1); pins(J); tick(10);

    t = cyc;
    pins(SE0);
    for (int d = 0; d < 2; d++) pulseExp(d, t, Ls[d], 2, SE0, "glitch2");
    tick(2); pins(J); tick(10);

    t = cyc;
    pins(SE1);
    for (int d = 0; d < 2; d++) pulseExp(d, t, Ls[d], 5, SE1, "se1");
    tick(5); pins(J); tick(10);

    // Transmit K: receive forced to J
    t = cyc;
    oe = 1'b1; doP = 1'b0; doN = 1'b1;
    for (int d = 0; d < 2; d++) wantSpan(d, t+1, t+10, J, 1'b0, 1'b0, "tx_mask");
    tick(10);
    t = cyc;
    oe = 1'b0; pins(K);
    for (int d = 0; d < 2; d++) begin
      wantSpan(d, t+1, t+TA+Fl[d], J, 1'b0, 1'b0, "tx_turnaround");
      want(d, t+TA+1+Fl[d], K, 1'b1, 1'b0, "tx_release");
      wantSpan(d, t+TA+2+Fl[d], t+TA+4+Fl[d], K, 1'b0, 1'b0, "tx_after");
    end
    tick(8);
    t = cyc;
    oe = 1'b1;
    for (int d = 0; d < 2; d++) wantSpan(d, t+1, t+4, J, 1'b0, 1'b0, "tx_forced_j");
    tick(4);
    t = cyc;
    oe = 1'b0; pins(J);
    for (int d = 0; d < 2; d++) wantSpan(d, t+1, t+8, J, 1'b0, 1'b0, "tx_idle");
    tick(8);

    // Bus reset threshold and exit
    t = cyc;
    pins(SE0);
    for (int d = 0; d < 2; d++) begin
      want(d, t+Ls[d], SE0, 1'b1, 1'b0, "se0_entry");
      want(d, t+Ls[d]+NSE0-2, SE0, 1'b0, 1'b0, "se0_119");
      want(d, t+Ls[d]+NSE0-1, SE0, 1'b0, 1'b1, "se0_120");
    end
    tick(130);
    t = cyc;
    pins(J);
    for (int d = 0; d < 2; d++) begin
      want(d, t+Ls[d]-1, SE0, 1'b0, 1'b1, "se0_hold");
      want(d, t+Ls[d], J, 1'b1, 1'b0, "se0_exit");
    end
    tick(10);

    // Long SE0: counter must saturate, not wrap
    t = cyc;
    pins(SE0);
    for (int d = 0; d < 2; d++) begin
      want(d, t+Ls[d]+NSE0-1, SE0, 1'b0, 1'b1, "se0_long");
      for (int k = 0; k < 4; k++) want(d, t+Ls[d]+nowrap[k], SE0, 1'b0, 1'b1, "se0_nowrap");
    end
    tick(1010);
    checks++;
    if (s0A !== 1'b1 || lsA !== SE0) begin
      errors++;
      $display("FAIL se0_long_direct dutA: ls=%b se0Long=%b", lsA, s0A);
    end
    checks++;
    if (s0B !== 1'b1 || lsB !== SE0) begin
      errors++;
      $display("FAIL se0_long_direct dutB: ls=%b se0Long=%b", lsB, s0B);
    end
    t = cyc;
    pins(J);
    for (int d = 0; d < 2; d++) want(d, t+Ls[d], J, 1'b1, 1'b0, "se0_long_exit");
    tick(10);

    // Reset mid-stream with the line at K
    pins(K);
    tick(10);
    t = cyc;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) wantSpan(d, t, t+2, J, 1'b0, 1'b0, "rst_mid");
    #1;
    checks++;
    if ({dInNA, dInPA, lsA, lcA, s0A} !== {J, J, 2'b00}) begin
      errors++;
      $display("FAIL rst_mid_direct dutA: %b", {dInNA, dInPA, lsA, lcA, s0A});
    end
    checks++;
    if ({dInNB, dInPB, lsB, lcB, s0B} !== {J, J, 2'b00}) begin
      errors++;
      $display("FAIL rst_mid_direct dutB: %b", {dInNB, dInPB, lsB, lcB, s0B});
    end
    tick(2);
    rst_n = 1'b1;
    t = cyc;
    for (int d = 0; d < 2; d++) begin
      wantSpan(d, t+1, t+Ls[d]-1, J, 1'b0, 1'b0, "rst_recover_j");
      want(d, t+Ls[d], K, 1'b1, 1'b0, "rst_recover_k");
    end
    tick(8);

    tick(2);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: never compared, required {ls,lc,se0Long}=%b%b%b",
               sb[0].nm, sb[0].d, sb[0].at, sb[0].ls, sb[0].lc, sb[0].s0);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
